tdm_demultiplexer_1_to_8: RTL and testbench

- Receive end of the 8-lane time-division link: takes one serial bit stream, one bit per slot, and distributes each bit to its lane.
- Each complete 8-slot frame is presented as a parallel word on a valid/ready output.
- Frame alignment comes from a frame_sync strobe marking slot 0.
- Sits downstream of the 8-to-1 lane multiplexer and restores its input_lines vector.

---
 rtl/tdm_pkg.sv | 15 +
 rtl/tdm_demultiplexer_1_to_8_if.sv | 35 +++
 rtl/tdm_slot_counter.sv | 39 +++
 rtl/tdm_demultiplexer_1_to_8.sv | 127 ++++++++++++
 tb/tb_tdm_demultiplexer_1_to_8.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/tdm_pkg.sv
// Shared types for the 8-lane TDM link.
// Used by both the multiplexer and demultiplexer sides.
package tdm_pkg;

  localparam int TDM_LANES = 8;
  localparam int TDM_SEL_W = $clog2(TDM_LANES);

  typedef enum logic {
    HUNT = 1'b0,
    RUN  = 1'b1
  } state_e;

  typedef logic [TDM_SEL_W-1:0] slot_t;

endpackage

// File: rtl/tdm_demultiplexer_1_to_8_if.sv
// Serial-in / parallel-out handshake bundle
// for the TDM demultiplexer.
interface tdm_demultiplexer_1_to_8_if #(
  parameter int N_LANES = 8
);

  logic               in_valid;
  logic               in_ready;
  logic               in_bit;
  logic               frame_sync;
  logic [N_LANES-1:0] out_lines;
  logic               out_valid;
  logic               out_ready;

  modport master (
    output in_valid,
    output in_bit,
    output frame_sync,
    output out_ready,
    input  in_ready,
    input  out_lines,
    input  out_valid
  );

  modport slave (
    input  in_valid,
    input  in_bit,
    input  frame_sync,
    input  out_ready,
    output in_ready,
    output out_lines,
    output out_valid
  );

endinterface

// File: rtl/tdm_slot_counter.sv
// Wrapping slot index with load-to-1 and hold;
// flags the final slot of a frame.
module tdm_slot_counter #(
  parameter int SEL_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             hold_i,
  input  logic             load1_i,
  output logic [SEL_W-1:0] cnt_o,
  output logic             last_o
);

  logic [SEL_W-1:0] cnt_q;
  logic [SEL_W-1:0] cnt_d;

  // resync load wins over counting; power-of-2 size wraps naturally
  always_comb begin
    cnt_d = cnt_q;
    if (load1_i) begin
      cnt_d = SEL_W'(1);
    end else if (!hold_i) begin
      cnt_d = cnt_q + SEL_W'(1);
    end
  end

  // slot index register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o  = cnt_q;
  assign last_o = &cnt_q;

endmodule

// File: rtl/tdm_demultiplexer_1_to_8.sv
// Receive side of the 8-lane TDM link: serial
// slots gathered into parallel frames on valid/ready.
module tdm_demultiplexer_1_to_8
  import tdm_pkg::*;
#(
  parameter int N_LANES       = TDM_LANES,
  parameter bit SYNC_REQUIRED = 1'b1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  tdm_demultiplexer_1_to_8_if.slave  bus,
  output logic [$clog2(N_LANES)-1:0] slot,
  output logic                       locked,
  output logic                       sync_err
);

  localparam int SEL_W = $clog2(N_LANES);
  localparam state_e RST_ST = SYNC_REQUIRED ? HUNT : RUN;

  state_e             state_q;
  state_e             state_d;
  logic [N_LANES-1:0] shadow_q;
  logic [N_LANES-1:0] shadow_d;
  logic [N_LANES-1:0] out_lines_q;
  logic [N_LANES-1:0] out_lines_d;
  logic               out_valid_q;
  logic               out_valid_d;
  logic               sync_err_q;
  logic               sync_err_d;

  logic [SEL_W-1:0]   slot_q;
  logic               last;
  logic               hold;
  logic               load1;
  logic               in_ready;
  logic               acc;

  tdm_slot_counter #(
    .SEL_W (SEL_W)
  ) u_slot (
    .clk     (clk),
    .rst_n   (rst_n),
    .hold_i  (hold),
    .load1_i (load1),
    .cnt_o   (slot_q),
    .last_o  (last)
  );

  // only the completing slot stalls, and only
  // while the previous frame is still unconsumed
  assign in_ready = !(state_q == RUN && last &&
                      out_valid_q && !bus.out_ready);
  assign acc      = bus.in_valid && in_ready;

  // next-state, slot control, shadow and output word
  always_comb begin
    state_d     = state_q;
    shadow_d    = shadow_q;
    out_lines_d = out_lines_q;
    out_valid_d = out_valid_q;
    sync_err_d  = 1'b0;
    hold        = 1'b1;
    load1       = 1'b0;

    if (out_valid_q && bus.out_ready) begin
      out_valid_d = 1'b0;
    end

    unique case (state_q)
      HUNT: begin
        if (acc && bus.frame_sync) begin
          shadow_d[0] = bus.in_bit;
          load1       = 1'b1;
          state_d     = RUN;
        end
      end
      RUN: begin
        if (acc) begin
          unique case (1'b1)
            (bus.frame_sync && slot_q != '0): begin
              shadow_d[0] = bus.in_bit;
              load1       = 1'b1;
              sync_err_d  = 1'b1;
            end
            default: begin
              shadow_d[slot_q] = bus.in_bit;
              hold             = 1'b0;
              if (last) begin
                out_lines_d = {bus.in_bit,
                               shadow_q[N_LANES-2:0]};
                out_valid_d = 1'b1;
              end
            end
          endcase
        end
      end
      default: begin
        state_d = RST_ST;
      end
    endcase
  end

  // state, shadow and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RST_ST;
      shadow_q    <= '0;
      out_lines_q <= '0;
      out_valid_q <= 1'b0;
      sync_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      shadow_q    <= shadow_d;
      out_lines_q <= out_lines_d;
      out_valid_q <= out_valid_d;
      sync_err_q  <= sync_err_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_lines = out_lines_q;
  assign bus.out_valid = out_valid_q;
  assign slot          = slot_q;
  assign locked        = (state_q == RUN);
  assign sync_err      = sync_err_q;

endmodule

// File: tb/tb_tdm_demultiplexer_1_to_8.sv
// Scoreboard bench for the TDM demultiplexer:
// frames queued on send, checked on output handshake.
module tb_tdm_demultiplexer_1_to_8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] slot;
  logic       locked;
  logic       sync_err;

  tdm_demultiplexer_1_to_8_if #(.N_LANES(8)) bus ();

  tdm_demultiplexer_1_to_8 #(
    .N_LANES       (8),
    .SYNC_REQUIRED (1'b1)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .slot     (slot),
    .locked   (locked),
    .sync_err (sync_err)
  );

  always #5 clk = ~clk;

  int         n_vec = 0;
  int         n_err = 0;
  int         cyc = 0;
  int         stalls = 0;
  logic [7:0] exp_q[$];
  int         pop_cyc[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // output monitor: a frame is consumed at the edge after
  // a negedge that sees out_valid && out_ready
  always @(negedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        chk("sb_nonempty", 32'(exp_q.size()), 32'd1);
      end else begin
        chk("frame", 32'(bus.out_lines), 32'(exp_q.pop_front()));
      end
      pop_cyc.push_back(cyc);
    end
  end

  task automatic send_bit(input logic b, input logic s);
    int w;
    w = 0;
    bus.in_valid   = 1'b1;
    bus.in_bit     = b;
    bus.frame_sync = s;
    @(negedge clk);
    while (!bus.in_ready && w < 40) begin
      w++;
      @(negedge clk);
    end
    if (w == 40) chk("in_ready_timeout", 32'(bus.in_ready), 32'd1);
    stalls += w;
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] word);
    for (int k = 0; k < 8; k++) begin
      if (k == 7) exp_q.push_back(word);
      send_bit(word[k], k == 0);
    end
  endtask

  task automatic idle(input int n);
    bus.in_valid   = 1'b0;
    bus.frame_sync = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.in_valid   = 1'b0;
    bus.frame_sync = 1'b0;
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] w;
    bus.in_valid   = 1'b0;
    bus.in_bit     = 1'b0;
    bus.frame_sync = 1'b0;
    bus.out_ready  = 1'b1;
    #12;
    chk("rst_lines", 32'(bus.out_lines), 32'h0);
    chk("rst_valid", 32'(bus.out_valid), 32'h0);
    chk("rst_slot", 32'(slot), 32'h0);
    chk("rst_locked", 32'(locked), 32'h0);
    chk("rst_syncerr", 32'(sync_err), 32'h0);
    chk("rst_inready", 32'(bus.in_ready), 32'h1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // basic frame, 1-cycle latency
    w = 8'h71;
    for (int k = 0; k < 7; k++) send_bit(w[k], k == 0);
    chk("t1_early", 32'(bus.out_valid), 32'h0);
    exp_q.push_back(w);
    send_bit(w[7], 1'b0);
    chk("t1_valid", 32'(bus.out_valid), 32'h1);
    chk("t1_lines", 32'(bus.out_lines), 32'h71);
    chk("t1_slot", 32'(slot), 32'h0);
    idle(2);
    chk("t1_clear", 32'(bus.out_valid), 32'h0);

    // unsynced bits in HUNT are dropped
    do_reset();
    for (int k = 0; k < 5; k++) send_bit(1'b1, 1'b0);
    chk("t2_hunt", 32'(locked), 32'h0);
    chk("t2_slot", 32'(slot), 32'h0);
    w = 8'hA5;
    send_bit(w[0], 1'b1);
    chk("t2_lock", 32'(locked), 32'h1);
    chk("t2_slot1", 32'(slot), 32'h1);
    for (int k = 1; k < 8; k++) begin
      if (k == 7) exp_q.push_back(w);
      send_bit(w[k], 1'b0);
    end
    idle(2);

    // back-to-back frames, full throughput
    pop_cyc.delete();
    stalls = 0;
    send_frame(8'h3C);
    send_frame(8'hC3);
    idle(2);
    chk("t3_count", 32'(pop_cyc.size()), 32'd2);
    if (pop_cyc.size() == 2)
      chk("t3_gap", 32'(pop_cyc[1] - pop_cyc[0]), 32'd8);
    chk("t3_stalls", 32'(stalls), 32'd0);

    // backpressure stalls only the final slot
    bus.out_ready = 1'b0;
    send_frame(8'h0F);
    idle(2);
    chk("t4_held", 32'(bus.out_valid), 32'h1);
    chk("t4_lines", 32'(bus.out_lines), 32'h0F);
    w = 8'h96;
    stalls = 0;
    for (int k = 0; k < 7; k++) send_bit(w[k], k == 0);
    chk("t4_nostall", 32'(stalls), 32'd0);
    exp_q.push_back(w);
    bus.in_valid   = 1'b1;
    bus.in_bit     = w[7];
    bus.frame_sync = 1'b0;
    @(negedge clk);
    chk("t4_rdy_lo", 32'(bus.in_ready), 32'h0);
    chk("t4_slot7", 32'(slot), 32'h7);
    chk("t4_stable", 32'(bus.out_lines), 32'h0F);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("t4_rdy_lo2", 32'(bus.in_ready), 32'h0);
    chk("t4_stable2", 32'(bus.out_lines), 32'h0F);
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("t4_rdy_hi", 32'(bus.in_ready), 32'h1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    chk("t4_reload", 32'(bus.out_lines), 32'h96);
    chk("t4_valid", 32'(bus.out_valid), 32'h1);
    idle(2);

    // misaligned sync at slot 4
    for (int k = 0; k < 4; k++) send_bit(1'b1, k == 0);
    chk("t5_slot4", 32'(slot), 32'h4);
    chk("t5_noerr", 32'(sync_err), 32'h0);
    w = 8'h5A;
    send_bit(w[0], 1'b1);
    chk("t5_err", 32'(sync_err), 32'h1);
    chk("t5_slot1", 32'(slot), 32'h1);
    chk("t5_lock", 32'(locked), 32'h1);
    send_bit(w[1], 1'b0);
    chk("t5_pulse", 32'(sync_err), 32'h0);
    for (int k = 2; k < 8; k++) begin
      if (k == 7) exp_q.push_back(w);
      send_bit(w[k], 1'b0);
    end
    idle(2);

    // async reset mid-frame with a pending word
    bus.out_ready = 1'b0;
    send_frame(8'h11);
    w = 8'hE7;
    for (int k = 0; k < 3; k++) send_bit(w[k], k == 0);
    chk("t6_pend", 32'(bus.out_valid), 32'h1);
    chk("t6_slot3", 32'(slot), 32'h3);
    bus.in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_valid", 32'(bus.out_valid), 32'h0);
    chk("t6_slot", 32'(slot), 32'h0);
    chk("t6_locked", 32'(locked), 32'h0);
    chk("t6_lines", 32'(bus.out_lines), 32'h0);
    exp_q.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    send_frame(w);
    idle(3);
    chk("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
